// File: rtl/uart_aes_pkg.sv
// Shared constants for the UART-to-AES receive path: bit-FSM encoding and frame/block sizes.
// Frame length depends on UART_PARITY_EN (8E1 when defined, 8N1 otherwise).
package uart_aes_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

`ifdef UART_PARITY_EN
   localparam int unsigned FRAME_BITS = 11;
`else
   localparam int unsigned FRAME_BITS = 10;
`endif

   localparam int unsigned AES_BLOCK_BYTES = 16;

endpackage

// File: rtl/uart_byte_rx.sv
// Single-byte UART receiver: 2-FF synchroniser, bit FSM, baud counter, parity/stop checks.
// Even parity is checked only when UART_PARITY_EN is defined.
module uart_byte_rx
   import uart_aes_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err,
`ifdef UART_PARITY_EN
   output logic       parity_err,
`endif
   output logic       start_edge,
   output logic       idle
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic          rx_m, rx_s, rx_d;
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          tick, stop_sample;
`ifdef UART_PARITY_EN
   logic          par_bad;
`endif

   assign tick        = (cnt == BIT_LAST);
   assign idle        = (state == ST_IDLE);
   // Re-arming requires rx_s to have been high, so a stuck-low line after a framing error is ignored.
   assign start_edge  = idle && !rx_s && rx_d;
   assign stop_sample = (state == ST_STOP) && tick;
   assign frame_err   = stop_sample && !rx_s;
   assign rx_byte     = shreg;
`ifdef UART_PARITY_EN
   assign parity_err  = (state == ST_PARITY) && tick && (rx_s != ^shreg);
   assign byte_valid  = stop_sample && rx_s && !par_bad;
`else
   assign byte_valid  = stop_sample && rx_s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
`ifdef UART_PARITY_EN
         par_bad <= 1'b0;
`endif
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (start_edge) state <= ST_START;
            end
            ST_START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  cnt     <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
               if (tick) begin
                  cnt     <= '0;
                  par_bad <= (rx_s != ^shreg);
                  state   <= ST_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (tick) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
`ifdef UART_PARITY_EN
                  par_bad <= 1'b0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_block_rx.sv
// UART block receiver: assembles BLOCK_BYTES bytes into one word behind a one-deep ready/valid register.
// Optional even parity (8E1) is enabled by defining UART_PARITY_EN.
module uart_block_rx
   import uart_aes_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned BLOCK_BYTES  = AES_BLOCK_BYTES,
   parameter int unsigned MSB_FIRST    = 1,
   parameter int unsigned TIMEOUT_BITS = 32
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     Rx,
   output logic [8*BLOCK_BYTES-1:0] Block_Data,
   output logic                     Block_Valid,
   input  logic                     Block_Ready,
   output logic                     Frame_Err,
   output logic                     Overrun,
   output logic                     Timeout
`ifdef UART_PARITY_EN
   ,
   output logic                     Parity_Err
`endif
);

   localparam int unsigned BW       = 8 * BLOCK_BYTES;
   localparam int unsigned CNT_W    = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BLOCK_BYTES - 1);
   localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TO_W     = $clog2(TO_LIMIT + 2);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((TO_LIMIT > 0) ? TO_LIMIT - 1 : 0);

   logic [7:0]       rx_byte;
   logic             byte_valid, frame_err, start_edge, idle;
`ifdef UART_PARITY_EN
   logic             parity_err;
`endif
   logic [BW-1:0]    asm_data, asm_next;
   logic [CNT_W-1:0] byte_cnt;
   logic [TO_W-1:0]  idle_cnt;
   int unsigned      slot;
   logic             last_byte, load, to_fire;

   uart_byte_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk        (Clk),
      .rst        (Rst),
      .rx         (Rx),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err),
`ifdef UART_PARITY_EN
      .parity_err (parity_err),
`endif
      .start_edge (start_edge),
      .idle       (idle)
   );

   // The completed block includes the byte arriving this cycle, so the output loads from asm_next.
   always_comb begin
      asm_next = asm_data;
      slot     = (MSB_FIRST != 0) ? (BLOCK_BYTES - 1 - 32'(byte_cnt)) : 32'(byte_cnt);
      for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
         if (i == slot) asm_next[8*i +: 8] = rx_byte;
      end
   end

   assign last_byte = byte_valid && (byte_cnt == LAST_SLOT);
   assign load      = last_byte && (!Block_Valid || Block_Ready);
   assign to_fire   = (TIMEOUT_BITS != 0) && idle && (byte_cnt != '0) && !start_edge
                      && (idle_cnt == TO_LAST);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         asm_data    <= '0;
         byte_cnt    <= '0;
         idle_cnt    <= '0;
         Block_Data  <= '0;
         Block_Valid <= 1'b0;
         Frame_Err   <= 1'b0;
         Overrun     <= 1'b0;
         Timeout     <= 1'b0;
`ifdef UART_PARITY_EN
         Parity_Err  <= 1'b0;
`endif
      end else begin
         Frame_Err <= frame_err;
         Overrun   <= last_byte && Block_Valid && !Block_Ready;
         Timeout   <= to_fire;
`ifdef UART_PARITY_EN
         Parity_Err <= parity_err;
`endif
         if (byte_valid) begin
            asm_data <= asm_next;
            byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
         end else if (to_fire) begin
            byte_cnt <= '0;
         end

         if (!idle || byte_cnt == '0 || start_edge || to_fire) idle_cnt <= '0;
         else idle_cnt <= idle_cnt + 1'b1;

         if (load) begin
            Block_Data  <= asm_next;
            Block_Valid <= 1'b1;
         end else if (Block_Valid && Block_Ready) begin
            Block_Valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_block_rx.sv
// Directed bench for uart_block_rx at CLKS_PER_BIT=8, 16-byte blocks, MSB_FIRST=1, TIMEOUT_BITS=4.
// Builds with or without UART_PARITY_EN.
module tb_uart_block_rx;

   localparam int unsigned C  = 8;
   localparam int unsigned BB = 16;

   logic          Clk = 1'b0;
   logic          Rst, Rx, Block_Ready;
   logic [127:0]  Block_Data;
   logic          Block_Valid, Frame_Err, Overrun, Timeout;
`ifdef UART_PARITY_EN
   logic          Parity_Err;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int n_ferr = 0, n_ovr = 0, n_to = 0, n_par = 0;

   uart_block_rx #(
      .CLKS_PER_BIT(C),
      .BLOCK_BYTES (BB),
      .MSB_FIRST   (1),
      .TIMEOUT_BITS(4)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .Rx         (Rx),
      .Block_Data (Block_Data),
      .Block_Valid(Block_Valid),
      .Block_Ready(Block_Ready),
      .Frame_Err  (Frame_Err),
      .Overrun    (Overrun),
      .Timeout    (Timeout)
`ifdef UART_PARITY_EN
      ,
      .Parity_Err (Parity_Err)
`endif
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (Frame_Err) n_ferr++;
      if (Overrun)   n_ovr++;
      if (Timeout)   n_to++;
`ifdef UART_PARITY_EN
      if (Parity_Err) n_par++;
`endif
   end

   typedef struct {
      bit         glitch;
      logic [7:0] data;
      logic       stop_b;
      int         exp_ferr;
      logic       exp_valid;
   } vec_t;

   vec_t tbl[18];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic hold_bit(input logic v);
      Rx = v;
      repeat (C) @(posedge Clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic bad_par);
      hold_bit(1'b0);
      for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_PARITY_EN
      hold_bit((^d) ^ bad_par);
`else
      if (bad_par) hold_bit(1'b1);
`endif
      hold_bit(stop_b);
   endtask

   task automatic idle_cycles(input int n);
      Rx = 1'b1;
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic send_block(input logic [7:0] first);
      for (int i = 0; i < BB; i++) send_byte(first + 8'(i), 1'b1, 1'b0);
   endtask

   function automatic logic [127:0] block_of(input logic [7:0] first);
      logic [127:0] b;
      for (int i = 0; i < BB; i++) b[8*(BB-1-i) +: 8] = first + 8'(i);
      return b;
   endfunction

   task automatic accept();
      Block_Ready = 1'b1;
      @(posedge Clk);
      #1;
      Block_Ready = 1'b0;
   endtask

   initial begin
      int f0, o0, t0, to_at;
      logic [127:0] held;

      // 16 good bytes with a framing-error byte after slot 3 and a glitch after slot 7
      begin
         int k = 0;
         for (int i = 0; i < 16; i++) begin
            tbl[k] = '{1'b0, 8'(i), 1'b1, 0, (i == 15)};
            k++;
            if (i == 3) begin
               tbl[k] = '{1'b0, 8'hA5, 1'b0, 1, 1'b0};
               k++;
            end
            if (i == 7) begin
               tbl[k] = '{1'b1, 8'h00, 1'b1, 0, 1'b0};
               k++;
            end
         end
      end

      Rst = 1'b1; Rx = 1'b1; Block_Ready = 1'b0;
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b0;
      @(negedge Clk);
      check("reset_valid", Block_Valid, 0);
      check("reset_data", Block_Data, 0);
      check("reset_pulses", {Frame_Err, Overrun, Timeout}, 0);
      @(posedge Clk); #1;
      idle_cycles(4);

      for (int i = 0; i < 18; i++) begin
         f0 = n_ferr;
         if (tbl[i].glitch) begin
            Rx = 1'b0;
            repeat (3) @(posedge Clk);
            #1;
            idle_cycles(2 * C);
         end else begin
            send_byte(tbl[i].data, tbl[i].stop_b, 1'b0);
            if (!tbl[i].stop_b) idle_cycles(2 * C);
         end
         check($sformatf("vec%0d_ferr", i), 128'(n_ferr - f0), 128'(tbl[i].exp_ferr));
         check($sformatf("vec%0d_valid", i), Block_Valid, tbl[i].exp_valid);
      end
      check("blk0_data", Block_Data, block_of(8'h00));
      idle_cycles(40);
      check("blk0_hold_valid", Block_Valid, 1);
      check("blk0_hold_data", Block_Data, block_of(8'h00));
      check("no_spurious_to", 128'(n_to), 0);
      accept();
      @(negedge Clk);
      check("blk0_drop_valid", Block_Valid, 0);
      @(posedge Clk); #1;

      // Overrun: consumer stalled for two full blocks
      o0 = n_ovr;
      send_block(8'h20);
      check("ovr_first_valid", Block_Valid, 1);
      send_block(8'h30);
      check("ovr_count", 128'(n_ovr - o0), 1);
      check("ovr_held_data", Block_Data, block_of(8'h20));
      accept();
      @(negedge Clk);
      check("ovr_drop_valid", Block_Valid, 0);
      @(posedge Clk); #1;

      // Timeout: 5 bytes then idle; the 5 bytes must not leak into the next block
      t0 = n_to;
      for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i), 1'b1, 1'b0);
      to_at = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge Clk);
         if (Timeout && to_at < 0) to_at = i;
      end
      @(posedge Clk); #1;
      check("to_count", 128'(n_to - t0), 1);
      n_tests++;
      if (to_at < 30 || to_at > 34) begin
         n_fail++;
         $display("FAIL to_latency: got %0d cycles expected 30..34", to_at);
      end
      check("to_no_valid", Block_Valid, 0);
      send_block(8'h40);
      check("to_next_block", Block_Data, block_of(8'h40));
      check("to_next_valid", Block_Valid, 1);
      accept();

      // Reset mid-byte 7 while a block is held
      send_block(8'h50);
      for (int i = 0; i < 6; i++) send_byte(8'h70 + 8'(i), 1'b1, 1'b0);
      held = Block_Data;
      check("rst_pre_data", held, block_of(8'h50));
      Rx = 1'b0;
      repeat (3 * C) @(posedge Clk);
      #1;
      Rst = 1'b1; Rx = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      check("rst_mid_valid", Block_Valid, 0);
      check("rst_mid_data", Block_Data, 0);
      check("rst_mid_pulses", {Frame_Err, Overrun, Timeout}, 0);
      idle_cycles(2 * C);
      send_block(8'h60);
      check("rst_after_data", Block_Data, block_of(8'h60));
      check("rst_after_valid", Block_Valid, 1);
      accept();

`ifdef UART_PARITY_EN
      begin
         int p0 = n_par;
         send_byte(8'h01, 1'b1, 1'b1);
         check("parity_err", 128'(n_par - p0), 1);
         p0 = n_par;
         send_byte(8'h01, 1'b1, 1'b0);
         check("parity_ok", 128'(n_par - p0), 0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_block_rx.md
# uart_block_rx

Parametrised UART receiver that deserialises bytes from `Rx` and assembles them into a `BLOCK_BYTES`-wide word for the AES datapath. It is the successor to the fixed single-byte receive path behind `Top`, and sits between the `Rx` pin and the cipher core. It adds a ready/valid output handshake, overrun detection, framing-error reporting, an inter-byte timeout that discards partial blocks, and optional parity.

## Interface
- `CLKS_PER_BIT`, default 434: `Clk` cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `BLOCK_BYTES`, default 16: bytes per output block (one AES-128 state).
- `MSB_FIRST`, default 1: if 1, the first received byte lands in `Block_Data[8*BLOCK_BYTES-1 -: 8]`; if 0, it lands in `[7:0]`.
- `TIMEOUT_BITS`, default 32: idle bit-times after which a partial block is discarded; 0 disables the timeout.
- Ports:
- `Clk`  in  1  single clock; all logic is on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Rx`  in  1  asynchronous serial input; idle high; 8N1 framing (8E1 when `UART_PARITY_EN` is defined).
- `Block_Data`  out  8*BLOCK_BYTES  assembled block; stable while `Block_Valid` is high.
- `Block_Valid`  out  1  block available.
- `Block_Ready`  in  1  consumer accepts; transfer occurs when `Block_Valid && Block_Ready`.
- `Frame_Err`  out  1  one-cycle pulse: stop bit sampled low.
- `Overrun`  out  1  one-cycle pulse: a completed block was dropped.
- `Timeout`  out  1  one-cycle pulse: a partial block was discarded.
- `Parity_Err`  out  1  one-cycle pulse; present only with `UART_PARITY_EN`.

## Operation
- `Rx` passes through a 2-FF synchroniser. All sampling uses the synchronised signal `rx_s`.
- Bit FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE → START on a falling edge of `rx_s`.
  - In START, `rx_s` is resampled at `CLKS_PER_BIT/2`. If it is high, the start was a glitch: return to IDLE with no pulse. If it is low, go to DATA.
  - DATA samples 8 bits, LSB first, each exactly `CLKS_PER_BIT` after the previous sample.
  - STOP samples once. Low → `Frame_Err` pulse, byte discarded, and the FSM waits in IDLE until `rx_s` is high before re-arming. High → byte committed.
- Assembly register: `byte_cnt` counts 0..BLOCK_BYTES-1. Each committed byte is written to its slot and `byte_cnt` increments. On the last byte, `byte_cnt` wraps to 0 and the block is offered to the output register.
- Output register (one-deep skid):
  - If empty, or emptied in the same cycle (`Block_Valid && Block_Ready`), it loads the block and `Block_Valid` is 1 on the next cycle.
  - If full and not being accepted, the new block is dropped, `Overrun` pulses, and the held block is untouched.
- Timeout: while `byte_cnt != 0` and the FSM is IDLE, an idle counter runs. When it reaches `TIMEOUT_BITS*CLKS_PER_BIT`, `byte_cnt` is set to 0 and `Timeout` pulses once. Any start edge clears the idle counter.
- A frame-errored byte does not reset `byte_cnt`.
- Reset (any cycle, including mid-byte or while holding a block): FSM to IDLE, `byte_cnt`=0, all counters 0, `Block_Data`=0, `Block_Valid`=0, and all error pulses 0. The synchroniser flops reset to 1.

## Timing
- Let t = the cycle in which the falling edge is seen on `rx_s` (2 cycles after the pin edge).
- Data bit k is sampled at t + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- The stop bit is sampled at t + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT (10· with parity).
- `Block_Valid` rises 1 cycle after the stop sample of the last byte.
- Error pulses are asserted 1 cycle after the offending sample.
- `Block_Valid` drops the cycle after acceptance unless a new block loads in that same cycle.
- Back-to-back frames with no idle time are received without loss.

## Configuration
- `UART_PARITY_EN` defined:
  - A PARITY state follows DATA and samples the even-parity bit.
  - On mismatch, `Parity_Err` pulses 1 cycle after the parity sample and the byte is discarded. STOP is still checked.
- `UART_PARITY_EN` undefined:
  - No PARITY state and no `Parity_Err` port; the frame is 8N1.

## Structure
- Shared package `uart_aes_pkg` holds:
  - the bit-FSM state encoding;
  - the `FRAME_BITS` constant;
  - the AES block width constant `AES_BLOCK_BYTES` = 16.
- Sub-module `uart_byte_rx` contains the synchroniser, bit FSM, baud counter, and parity/stop checks. It outputs a `byte` + `byte_valid` strobe plus error strobes.
- The top level contains block assembly, the output register, and the timeout logic.

## Test plan
- CLKS_PER_BIT=8: send bytes 0x00..0x0F → `Block_Data` = 0x000102…0F (MSB_FIRST=1), `Block_Valid` high until `Block_Ready`.
- Hold `Block_Ready`=0 and send 32 bytes → first block held unchanged, `Overrun` pulses once, second block lost.
- Byte 0xA5 with stop bit = 0 → `Frame_Err` pulse, `byte_cnt` unchanged, next valid byte fills the same slot.
- 3-cycle low glitch on `Rx` → no byte committed, no error pulse.
- 5 bytes then idle with TIMEOUT_BITS=4 → `Timeout` after 32 idle cycles; the next 16 bytes form a clean block.
- `Rst` mid-byte 7 while `Block_Valid`=1 → all outputs 0 next cycle; a subsequent full block is received correctly. With `UART_PARITY_EN`: wrong parity on 0x01 → `Parity_Err` pulse.
